graphics_compositor: RTL and testbench

Parametrised, pipelined successor to the combinational sprite/maze mixer. It converts VGA beam counters to rotated playfield coordinates and a framebuffer address, all registered. It composites NUM_SPRITES sprite layers plus the maze layer by fixed index priority. A per-sprite enable mask and background colour are loaded over a valid/ready handshake and take effect only at vblank start, so there is no mid-frame tearing.

---
 rtl/graphics_compositor_if.sv | 22 ++
 rtl/graphics_compositor.sv | 158 +++++++++++++++
 tb/tb_graphics_compositor.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/graphics_compositor_if.sv
// Configuration channel of the graphics compositor: a valid/ready offer of
// a sprite enable mask and background colour, plus the "accepted, not yet applied" flag.
interface graphics_compositor_if #(
    parameter int NUM_SPRITES = 6,
    parameter int COLOR_W     = 8
) ();
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [NUM_SPRITES-1:0] cfg_enable_mask;
    logic [COLOR_W-1:0]     cfg_bg_color;
    logic                   cfg_pending;

    modport master (
        output cfg_valid, cfg_enable_mask, cfg_bg_color,
        input  cfg_ready, cfg_pending
    );

    modport slave (
        input  cfg_valid, cfg_enable_mask, cfg_bg_color,
        output cfg_ready, cfg_pending
    );
endinterface

// File: rtl/graphics_compositor.sv
// Two-stage beam-to-playfield mapper and priority sprite/maze compositor.
// Optional macro GFX_COLLISION_EN builds the per-frame pacman/ghost collision flag.
module graphics_compositor #(
    parameter int NUM_SPRITES = 6,
    parameter int COLOR_W     = 8,
    parameter int XMAX        = 240,
    parameter int YMAX        = 320,
    parameter int ROW_PITCH   = 264,
    parameter int YOFFSET     = 24,
    parameter int ADDR_W      = 16,
    parameter int TRANSPARENT = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     hc,
    input  logic [9:0]                     vc,
    input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_colors,
    input  logic [COLOR_W-1:0]             maze_color,
    graphics_compositor_if.slave           cfg,
    output logic [8:0]                     xpos,
    output logic [8:0]                     ypos,
    output logic [ADDR_W-1:0]              address,
    output logic [COLOR_W-1:0]             color,
    output logic                           color_active,
    output logic                           frame_start,
    output logic                           collision
);
    localparam logic [9:0]         X_LAST = 10'(XMAX - 1);
    localparam logic [8:0]         Y_LAST = 9'(YMAX - 1);
    localparam logic [9:0]         Y_LO   = 10'(YOFFSET);
    localparam logic [9:0]         Y_HI   = 10'(YOFFSET + ROW_PITCH);
    localparam logic [COLOR_W-1:0] TRANSP = COLOR_W'(TRANSPARENT);

    logic [8:0]             xpos_q, ypos_q, xpos_d, ypos_d;
    logic [ADDR_W-1:0]      address_q, address_d;
    logic                   active1_q, in_view;
    logic [COLOR_W-1:0]     color_q, color_d;
    logic                   color_active_q, frame_start_q;
    logic [NUM_SPRITES-1:0] mask_q, shadow_mask_q;
    logic [COLOR_W-1:0]     bg_q, shadow_bg_q;
    logic                   pending_q;
    logic                   boundary, accept;

    assign in_view  = (hc < 10'd640) && (vc < 10'd480);
    assign boundary = (vc == 10'd480) && (hc == 10'd0);
    assign accept   = cfg.cfg_valid && !pending_q;

    // Beam counters rotate 90 degrees: vertical beam runs along playfield x.
    always_comb begin
        xpos_d    = '0;
        ypos_d    = '0;
        address_d = '1;
        if (vc < 10'd480) begin
            xpos_d = 9'(X_LAST - {1'b0, vc[9:1]});
            ypos_d = in_view ? hc[9:1] : Y_LAST;
        end
        if (({1'b0, ypos_d} >= Y_LO) && ({1'b0, ypos_d} < Y_HI)) begin
            address_d = ADDR_W'(18'(xpos_d) * 18'(ROW_PITCH) + 18'(ypos_d) - 18'(YOFFSET));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xpos_q    <= '0;
            ypos_q    <= '0;
            address_q <= '1;
            active1_q <= 1'b0;
        end else begin
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            address_q <= address_d;
            active1_q <= in_view;
        end
    end

    logic [COLOR_W-1:0]     chan [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] vis;

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_chan
        assign chan[gi] = sprite_colors[gi*COLOR_W +: COLOR_W];
        assign vis[gi]  = mask_q[gi] && (chan[gi] != TRANSP);
    end

    // Walk from the lowest priority upward so the lowest visible index wins.
    always_comb begin
        color_d = (maze_color != TRANSP) ? maze_color : bg_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (vis[i]) color_d = chan[i];
        end
        if (!active1_q) color_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_q        <= '0;
            color_active_q <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            color_q        <= color_d;
            color_active_q <= active1_q;
            frame_start_q  <= boundary;
        end
    end

    // Config only lands in the active registers on the vblank boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= 1'b0;
            mask_q        <= '1;
            bg_q          <= '0;
            shadow_mask_q <= '0;
            shadow_bg_q   <= '0;
        end else if (boundary && accept) begin
            mask_q <= cfg.cfg_enable_mask;
            bg_q   <= cfg.cfg_bg_color;
        end else if (boundary && pending_q) begin
            mask_q    <= shadow_mask_q;
            bg_q      <= shadow_bg_q;
            pending_q <= 1'b0;
        end else if (accept) begin
            shadow_mask_q <= cfg.cfg_enable_mask;
            shadow_bg_q   <= cfg.cfg_bg_color;
            pending_q     <= 1'b1;
        end
    end

`ifdef GFX_COLLISION_EN
    logic hit, flag_q, collision_q;

    assign hit = active1_q && vis[NUM_SPRITES-1] && (|vis[NUM_SPRITES-2:0]);

    // A hit on the boundary cycle seeds the new frame's flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q      <= 1'b0;
            collision_q <= 1'b0;
        end else if (boundary) begin
            collision_q <= flag_q;
            flag_q      <= hit;
        end else begin
            flag_q <= flag_q || hit;
        end
    end

    assign collision = collision_q;
`else
    assign collision = 1'b0;
`endif

    assign xpos            = xpos_q;
    assign ypos            = ypos_q;
    assign address         = address_q;
    assign color           = color_q;
    assign color_active    = color_active_q;
    assign frame_start     = frame_start_q;
    assign cfg.cfg_ready   = !pending_q;
    assign cfg.cfg_pending = pending_q;
endmodule

// File: tb/tb_graphics_compositor.sv
// Directed plus randomized bench for graphics_compositor against a behavioural
// model of the geometry, priority mixing, config handshake and collision flag.
module tb_graphics_compositor;
    localparam int NS = 6;
    localparam int CW = 8;

`ifdef GFX_COLLISION_EN
    localparam bit COLL_ON = 1'b1;
`else
    localparam bit COLL_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [9:0]        hc, vc;
    logic [NS*CW-1:0]  sprite_colors;
    logic [CW-1:0]     maze_color;
    logic [8:0]        xpos, ypos;
    logic [15:0]       address;
    logic [CW-1:0]     color;
    logic              color_active, frame_start, collision;

    graphics_compositor_if #(.NUM_SPRITES(NS), .COLOR_W(CW)) cfg_bus ();

    graphics_compositor dut (
        .clk          (clk),
        .rst          (rst),
        .hc           (hc),
        .vc           (vc),
        .sprite_colors(sprite_colors),
        .maze_color   (maze_color),
        .cfg          (cfg_bus.slave),
        .xpos         (xpos),
        .ypos         (ypos),
        .address      (address),
        .color        (color),
        .color_active (color_active),
        .frame_start  (frame_start),
        .collision    (collision)
    );

    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    bit [NS-1:0] m_mask, m_sh_mask;
    bit [CW-1:0] m_bg, m_sh_bg;
    bit          m_pending, m_act1, m_flag, m_coll;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int compose(input bit [NS-1:0] mask, input bit [CW-1:0] bg,
                                   input logic [NS*CW-1:0] spr, input logic [CW-1:0] maze);
        int res;
        bit found;
        res   = int'(bg);
        found = 1'b0;
        if (maze != 0) res = int'(maze);
        for (int i = 0; i < NS; i++) begin
            if (!found && mask[i] && (spr[i*CW +: CW] != 0)) begin
                res   = int'(spr[i*CW +: CW]);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // One clock with the currently driven inputs; all outputs checked against the model.
    task automatic cycle();
        int x, y, a, ec;
        bit act, bnd, acc, hit;
        bit [NS-1:0] vis;
        act = (hc < 640) && (vc < 480);
        if (vc < 480) begin
            x = 239 - int'(vc) / 2;
            y = act ? int'(hc) / 2 : 319;
        end else begin
            x = 0;
            y = 0;
        end
        a   = (y >= 24 && y < 24 + 264) ? ((x * 264 + y - 24) % 65536) : 65535;
        ec  = m_act1 ? compose(m_mask, m_bg, sprite_colors, maze_color) : 0;
        for (int i = 0; i < NS; i++) vis[i] = m_mask[i] && (sprite_colors[i*CW +: CW] != 0);
        hit = m_act1 && vis[NS-1] && (vis[NS-2:0] != 0);
        bnd = (hc == 0) && (vc == 480);
        acc = cfg_bus.cfg_valid && !m_pending;
        if (bnd) begin
            if (acc) begin
                m_mask = cfg_bus.cfg_enable_mask;
                m_bg   = cfg_bus.cfg_bg_color;
            end else if (m_pending) begin
                m_mask    = m_sh_mask;
                m_bg      = m_sh_bg;
                m_pending = 1'b0;
            end
            m_coll = m_flag;
            m_flag = hit;
        end else begin
            if (acc) begin
                m_sh_mask = cfg_bus.cfg_enable_mask;
                m_sh_bg   = cfg_bus.cfg_bg_color;
                m_pending = 1'b1;
            end
            m_flag = m_flag || hit;
        end
        @(posedge clk);
        #1;
        check("xpos", 32'(xpos), 32'(x));
        check("ypos", 32'(ypos), 32'(y));
        check("address", 32'(address), 32'(a));
        check("color", 32'(color), 32'(ec));
        check("color_active", 32'(color_active), 32'(m_act1));
        check("frame_start", 32'(frame_start), 32'(bnd));
        check("cfg_pending", 32'(cfg_bus.cfg_pending), 32'(m_pending));
        check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(!m_pending));
        check("collision", 32'(collision), 32'(COLL_ON && m_coll));
        m_act1 = act;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_mask    = '1;
        m_bg      = '0;
        m_pending = 1'b0;
        m_act1    = 1'b0;
        m_flag    = 1'b0;
        m_coll    = 1'b0;
        check("rst_xpos", 32'(xpos), 32'd0);
        check("rst_ypos", 32'(ypos), 32'd0);
        check("rst_address", 32'(address), 32'hFFFF);
        check("rst_color", 32'(color), 32'd0);
        check("rst_color_active", 32'(color_active), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_cfg_pending", 32'(cfg_bus.cfg_pending), 32'd0);
        check("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check("rst_collision", 32'(collision), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        hc = '0;
        vc = '0;
        sprite_colors = '0;
        maze_color = '0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_enable_mask = '0;
        cfg_bus.cfg_bg_color = '0;
        m_sh_mask = '0;
        m_sh_bg = '0;
        do_reset();

        // Geometry and pipeline latency
        hc = 10'd0; vc = 10'd0; cycle();
        check("origin_xpos", 32'(xpos), 32'd239);
        check("origin_ypos", 32'(ypos), 32'd0);
        check("origin_address", 32'(address), 32'hFFFF);
        hc = 10'd100; vc = 10'd10; cycle();
        check("origin_color_active", 32'(color_active), 32'd1);
        check("pix_xpos", 32'(xpos), 32'd234);
        check("pix_ypos", 32'(ypos), 32'd50);
        check("pix_address", 32'(address), 32'd61802);
        hc = 10'd700; vc = 10'd10; cycle();
        check("hblank_ypos", 32'(ypos), 32'd319);
        check("hblank_address", 32'(address), 32'hFFFF);
        hc = 10'd100; vc = 10'd10; cycle();
        check("hblank_color_active", 32'(color_active), 32'd0);
        check("hblank_color", 32'(color), 32'd0);

        // Priority mixing
        sprite_colors = {8'hFC, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h00};
        maze_color = 8'h03;
        cycle();
        check("prio_ch1", 32'(color), 32'hEF);

        // Offer mask=0 mid-frame, then a second offer while pending
        hc = 10'd100; vc = 10'd200;
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_enable_mask = 6'h00; cfg_bus.cfg_bg_color = 8'h00;
        cycle();
        cfg_bus.cfg_valid = 1'b0;
        check("offer_ready_low", 32'(cfg_bus.cfg_ready), 32'd0);
        check("offer_pending", 32'(cfg_bus.cfg_pending), 32'd1);
        cycle();
        check("pending_color_unchanged", 32'(color), 32'hEF);
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_enable_mask = 6'h3F; cfg_bus.cfg_bg_color = 8'h55;
        cycle(); cycle();
        check("held_offer_pending", 32'(cfg_bus.cfg_pending), 32'd1);
        hc = 10'd0; vc = 10'd480; cycle();
        check("boundary_frame_start", 32'(frame_start), 32'd1);
        check("boundary_pending_clear", 32'(cfg_bus.cfg_pending), 32'd0);
        check("boundary_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        hc = 10'd100; vc = 10'd10; cycle();
        cfg_bus.cfg_valid = 1'b0;
        check("held_offer_accepted", 32'(cfg_bus.cfg_pending), 32'd1);
        check("frame_start_one_cycle", 32'(frame_start), 32'd0);
        cycle();
        check("mask0_maze", 32'(color), 32'h03);
        hc = 10'd0; vc = 10'd480; cycle();

        // Offer on the exact boundary cycle applies immediately
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_enable_mask = 6'h3D; cfg_bus.cfg_bg_color = 8'h92;
        cycle();
        cfg_bus.cfg_valid = 1'b0;
        check("direct_pending_low", 32'(cfg_bus.cfg_pending), 32'd0);
        hc = 10'd100; vc = 10'd10; cycle();
        check("direct_pending_stays_low", 32'(cfg_bus.cfg_pending), 32'd0);
        cycle();
        check("mask_bit1_off", 32'(color), 32'hFC);
        sprite_colors = '0; maze_color = 8'h00; cycle();
        check("bg_color", 32'(color), 32'h92);

        // Reset mid-frame discards a pending config
        hc = 10'd100; vc = 10'd100;
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_enable_mask = 6'h00; cfg_bus.cfg_bg_color = 8'h44;
        cycle();
        cfg_bus.cfg_valid = 1'b0;
        check("pre_reset_pending", 32'(cfg_bus.cfg_pending), 32'd1);
        do_reset();
        hc = 10'd100; vc = 10'd10; sprite_colors = {40'h0, 8'h11}; cycle(); cycle();
        check("post_reset_mask_ones", 32'(color), 32'h11);

        // Collision across two frame boundaries
        sprite_colors = '0; hc = 10'd0; vc = 10'd480; cycle();
        hc = 10'd10; vc = 10'd10; cycle();
        sprite_colors = {8'hFC, 32'h0, 8'hE0}; hc = 10'd11; cycle();
        sprite_colors = '0; hc = 10'd0; vc = 10'd480; cycle();
        check("collision_set", 32'(collision), 32'(COLL_ON));
        hc = 10'd650; vc = 10'd10; cycle(); cycle();
        hc = 10'd0; vc = 10'd480; cycle();
        check("collision_clear", 32'(collision), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                hc = 10'd0; vc = 10'd480;
            end else begin
                hc = 10'($urandom_range(0, 799));
                vc = 10'($urandom_range(0, 524));
            end
            for (int i = 0; i < NS; i++) begin
                sprite_colors[i*CW +: CW] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            maze_color = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            cfg_bus.cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_bus.cfg_enable_mask = 6'($urandom);
            cfg_bus.cfg_bg_color = 8'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
